// File: rtl/dmem_responder_if.sv
// Request/response bundle between the MEM-stage requester and dmem_responder.
interface dmem_responder_if;
  logic        req_valid;
  logic        req_write;
  logic [15:0] req_addr;
  logic [15:0] req_wdata;
  logic        req_ready;
  logic        resp_valid;
  logic [15:0] resp_rdata;
  logic        resp_err;
  logic        busy;

  modport master (
    output req_valid, req_write, req_addr, req_wdata,
    input  req_ready, resp_valid, resp_rdata, resp_err, busy
  );

  modport slave (
    input  req_valid, req_write, req_addr, req_wdata,
    output req_ready, resp_valid, resp_rdata, resp_err, busy
  );
endinterface

// File: rtl/dmem_responder.sv
// 16-bit word data memory with wait states and a one-cycle response strobe; all state moves on the falling clock edge.
// Define DMEM_BOUNDS_CHECK_EN to flag word indices >= DEPTH as errors instead of wrapping.
module dmem_responder #(
  parameter int          DEPTH       = 1024,
  parameter int          WAIT_CYCLES = 2,
  parameter logic [15:0] INIT0       = 16'd2
) (
  input  logic             clock,
  input  logic             reset,
  dmem_responder_if.slave  bus
);

  localparam int IW = $clog2(DEPTH);
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] WAIT = 2'd1;
  localparam logic [1:0] RESP = 2'd2;
`ifdef DMEM_BOUNDS_CHECK_EN
  localparam logic BOUNDS_EN = 1'b1;
`else
  localparam logic BOUNDS_EN = 1'b0;
`endif

  // Only word 0 carries a non-zero power-up value; reset never touches the array.
  logic [15:0] mem_q [DEPTH] = '{0: INIT0, default: 16'd0};

  logic [1:0]  state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        wr_q, wr_d;
  logic [15:0] addr_q, addr_d;
  logic [15:0] wdata_q, wdata_d;
  logic        ready_q, ready_d;
  logic        busy_q, busy_d;
  logic        valid_q, valid_d;
  logic [15:0] rdata_q, rdata_d;
  logic        err_q, err_d;

  logic [14:0]   word_s;
  logic [IW-1:0] idx_s;
  logic          oob_s;
  logic          err_s;
  logic          access_s;

  assign word_s   = addr_q[15:1];
  assign idx_s    = word_s[IW-1:0];
  assign oob_s    = ({1'b0, word_s} >= 16'(DEPTH));
  assign err_s    = addr_q[0] | (BOUNDS_EN & oob_s);
  assign access_s = (state_q == WAIT) && (cnt_q == 4'd0);

  // Next-state and response logic for the IDLE/WAIT/RESP sequencer.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    wr_d    = wr_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    valid_d = valid_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    case (state_q)
      IDLE: begin
        if (bus.req_valid) begin
          wr_d    = bus.req_write;
          addr_d  = bus.req_addr;
          wdata_d = bus.req_wdata;
          cnt_d   = 4'(WAIT_CYCLES);
          state_d = WAIT;
        end else begin
          state_d = IDLE;
        end
      end
      WAIT: begin
        // The counter runs down to zero so the strobe rises WAIT_CYCLES+1 edges after acceptance.
        if (cnt_q == 4'd0) begin
          state_d = RESP;
          valid_d = 1'b1;
          err_d   = err_s;
          rdata_d = (wr_q || err_s) ? 16'd0 : mem_q[idx_s];
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      RESP: begin
        state_d = IDLE;
        valid_d = 1'b0;
        rdata_d = 16'd0;
        err_d   = 1'b0;
      end
      default: begin
        state_d = IDLE;
        valid_d = 1'b0;
        rdata_d = 16'd0;
        err_d   = 1'b0;
      end
    endcase
    ready_d = (state_d == IDLE);
    busy_d  = (state_d != IDLE);
  end

  // Control and output registers with synchronous reset.
  always_ff @(negedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      wr_q    <= 1'b0;
      addr_q  <= 16'd0;
      wdata_q <= 16'd0;
      ready_q <= 1'b1;
      busy_q  <= 1'b0;
      valid_q <= 1'b0;
      rdata_q <= 16'd0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      wr_q    <= wr_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      ready_q <= ready_d;
      busy_q  <= busy_d;
      valid_q <= valid_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  // Store port: a reset on the access edge suppresses the write.
  always_ff @(negedge clock) begin
    if (!reset && access_s && wr_q && !err_s) begin
      mem_q[idx_s] <= wdata_q;
    end
  end

  assign bus.req_ready  = ready_q;
  assign bus.busy       = busy_q;
  assign bus.resp_valid = valid_q;
  assign bus.resp_rdata = rdata_q;
  assign bus.resp_err   = err_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder (WAIT_CYCLES=2, DEPTH=1024); outputs sampled on rising edges, DUT acts on falling edges.
module tb_dmem_responder;
  logic clock = 1'b0;
  logic reset = 1'b1;
  int   pass_cnt = 0;
  int   total_cnt = 0;

  dmem_responder_if bus_if ();

  dmem_responder #(.DEPTH(1024), .WAIT_CYCLES(2), .INIT0(16'd2)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus_if.slave)
  );

  always #5 clock = ~clock;

  // Presents one request, holds it until accepted, then waits (bounded) for the response strobe.
  task automatic do_req(input logic w, input logic [15:0] a, input logic [15:0] d,
                        output logic [15:0] rd, output logic e, output logic to);
    logic acc;
    acc = 1'b0; to = 1'b1; rd = 16'hDEAD; e = 1'bx;
    @(posedge clock);
    bus_if.req_valid = 1'b1; bus_if.req_write = w; bus_if.req_addr = a; bus_if.req_wdata = d;
    for (int i = 0; i < 20; i++) begin
      acc = bus_if.req_ready;
      @(posedge clock);
      if (acc) break;
    end
    bus_if.req_valid = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (acc && bus_if.resp_valid) begin
        rd = bus_if.resp_rdata; e = bus_if.resp_err; to = 1'b0;
        break;
      end
      @(posedge clock);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(posedge clock);
    reset = 1'b0;
    @(posedge clock);
    total_cnt++; if (bus_if.req_ready !== 1'b1) $display("FAIL rst_ready got %b exp 1", bus_if.req_ready); else pass_cnt++;
    total_cnt++; if (bus_if.resp_valid !== 1'b0) $display("FAIL rst_valid got %b exp 0", bus_if.resp_valid); else pass_cnt++;
    total_cnt++; if (bus_if.resp_rdata !== 16'h0000) $display("FAIL rst_rdata got %h exp 0000", bus_if.resp_rdata); else pass_cnt++;
    total_cnt++; if (bus_if.resp_err !== 1'b0) $display("FAIL rst_err got %b exp 0", bus_if.resp_err); else pass_cnt++;
    total_cnt++; if (bus_if.busy !== 1'b0) $display("FAIL rst_busy got %b exp 0", bus_if.busy); else pass_cnt++;
  endtask

  // Load of word 0 traced edge by edge: strobe only after edge N+3, busy through N+3.
  task automatic test_latency();
    logic [4:0] exp_valid, exp_busy;
    exp_valid = 5'b01000;
    exp_busy  = 5'b01111;
    bus_if.req_valid = 1'b1; bus_if.req_write = 1'b0; bus_if.req_addr = 16'h0000; bus_if.req_wdata = 16'h0000;
    @(posedge clock);
    bus_if.req_valid = 1'b0;
    for (int k = 0; k < 5; k++) begin
      total_cnt++;
      if (bus_if.resp_valid !== exp_valid[k]) $display("FAIL lat_valid edge N+%0d got %b exp %b", k, bus_if.resp_valid, exp_valid[k]); else pass_cnt++;
      total_cnt++;
      if (bus_if.busy !== exp_busy[k]) $display("FAIL lat_busy edge N+%0d got %b exp %b", k, bus_if.busy, exp_busy[k]); else pass_cnt++;
      if (k == 3) begin
        total_cnt++; if (bus_if.resp_rdata !== 16'h0002) $display("FAIL lat_rdata got %h exp 0002", bus_if.resp_rdata); else pass_cnt++;
        total_cnt++; if (bus_if.resp_err !== 1'b0) $display("FAIL lat_err got %b exp 0", bus_if.resp_err); else pass_cnt++;
      end
      if (k == 4) begin
        total_cnt++; if (bus_if.req_ready !== 1'b1) $display("FAIL lat_ready_back got %b exp 1", bus_if.req_ready); else pass_cnt++;
      end
      @(posedge clock);
    end
  endtask

  task automatic test_store_load();
    logic [15:0] rd; logic e, to;
    do_req(1'b1, 16'h0002, 16'h0005, rd, e, to);
    total_cnt++; if (to || rd !== 16'h0000 || e !== 1'b0) $display("FAIL st2 rdata %h err %b timeout %b exp 0000/0/0", rd, e, to); else pass_cnt++;
    do_req(1'b0, 16'h0002, 16'h0000, rd, e, to);
    total_cnt++; if (to || rd !== 16'h0005 || e !== 1'b0) $display("FAIL ld2 rdata %h err %b timeout %b exp 0005/0/0", rd, e, to); else pass_cnt++;
    do_req(1'b0, 16'h0000, 16'h0000, rd, e, to);
    total_cnt++; if (to || rd !== 16'h0002 || e !== 1'b0) $display("FAIL ld0 rdata %h err %b timeout %b exp 0002/0/0", rd, e, to); else pass_cnt++;
  endtask

  // req_valid held across the whole transaction must yield exactly one response.
  task automatic test_held_valid();
    int pulses;
    pulses = 0;
    @(posedge clock);
    bus_if.req_valid = 1'b1; bus_if.req_write = 1'b0; bus_if.req_addr = 16'h0002;
    for (int k = 0; k < 5; k++) begin
      @(posedge clock);
      if (bus_if.resp_valid) pulses++;
    end
    bus_if.req_valid = 1'b0;
    for (int k = 0; k < 8; k++) begin
      @(posedge clock);
      if (bus_if.resp_valid) pulses++;
    end
    total_cnt++; if (pulses != 1) $display("FAIL held_valid pulses got %0d exp 1", pulses); else pass_cnt++;
  endtask

  task automatic test_misaligned();
    logic [15:0] rd; logic e, to;
    do_req(1'b1, 16'h0003, 16'hFFFF, rd, e, to);
    total_cnt++; if (to || rd !== 16'h0000 || e !== 1'b1) $display("FAIL mis_st rdata %h err %b timeout %b exp 0000/1/0", rd, e, to); else pass_cnt++;
    do_req(1'b0, 16'h0002, 16'h0000, rd, e, to);
    total_cnt++; if (to || rd !== 16'h0005 || e !== 1'b0) $display("FAIL mis_ld2 rdata %h err %b timeout %b exp 0005/0/0", rd, e, to); else pass_cnt++;
    do_req(1'b0, 16'h0001, 16'h0000, rd, e, to);
    total_cnt++; if (to || rd !== 16'h0000 || e !== 1'b1) $display("FAIL mis_ld rdata %h err %b timeout %b exp 0000/1/0", rd, e, to); else pass_cnt++;
  endtask

  task automatic test_reset_in_wait();
    logic [15:0] rd; logic e, to;
    do_req(1'b1, 16'h0004, 16'h1111, rd, e, to);
    total_cnt++; if (to || e !== 1'b0) $display("FAIL st4 err %b timeout %b exp 0/0", e, to); else pass_cnt++;
    @(posedge clock);
    bus_if.req_valid = 1'b1; bus_if.req_write = 1'b1; bus_if.req_addr = 16'h0004; bus_if.req_wdata = 16'h1234;
    @(posedge clock);
    bus_if.req_valid = 1'b0;
    total_cnt++; if (bus_if.busy !== 1'b1) $display("FAIL rw_accept busy got %b exp 1", bus_if.busy); else pass_cnt++;
    reset = 1'b1;
    @(posedge clock);
    reset = 1'b0;
    total_cnt++; if (bus_if.busy !== 1'b0 || bus_if.req_ready !== 1'b1 || bus_if.resp_valid !== 1'b0)
      $display("FAIL rw_abort busy %b ready %b valid %b exp 0/1/0", bus_if.busy, bus_if.req_ready, bus_if.resp_valid); else pass_cnt++;
    do_req(1'b0, 16'h0004, 16'h0000, rd, e, to);
    total_cnt++; if (to || rd !== 16'h1111 || e !== 1'b0) $display("FAIL rw_ld4 rdata %h err %b timeout %b exp 1111/0/0", rd, e, to); else pass_cnt++;
  endtask

  // Reset and a request on the same edge: the request is dropped.
  task automatic test_reset_with_req();
    @(posedge clock);
    bus_if.req_valid = 1'b1; bus_if.req_write = 1'b0; bus_if.req_addr = 16'h0000;
    reset = 1'b1;
    @(posedge clock);
    bus_if.req_valid = 1'b0;
    reset = 1'b0;
    @(posedge clock);
    total_cnt++; if (bus_if.busy !== 1'b0 || bus_if.resp_valid !== 1'b0)
      $display("FAIL rst_req busy %b valid %b exp 0/0", bus_if.busy, bus_if.resp_valid); else pass_cnt++;
  endtask

  task automatic test_wrap();
    logic [15:0] rd; logic e, to;
    logic [15:0] exp_rd; logic exp_e;
`ifdef DMEM_BOUNDS_CHECK_EN
    exp_rd = 16'h0000; exp_e = 1'b1;
`else
    exp_rd = 16'h0002; exp_e = 1'b0;
`endif
    do_req(1'b0, 16'h0800, 16'h0000, rd, e, to);
    total_cnt++; if (to || rd !== exp_rd || e !== exp_e) $display("FAIL wrap rdata %h err %b timeout %b exp %h/%b/0", rd, e, to, exp_rd, exp_e); else pass_cnt++;
  endtask

  initial begin
    bus_if.req_valid = 1'b0;
    bus_if.req_write = 1'b0;
    bus_if.req_addr  = 16'h0000;
    bus_if.req_wdata = 16'h0000;
    test_reset();
    test_latency();
    test_store_load();
    test_held_valid();
    test_misaligned();
    test_reset_in_wait();
    test_reset_with_req();
    test_wrap();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
